// File: rtl/motion_detect_pkg.sv
// Shared types and constants for the motion-detect stream stages.
// The highlight stage and the bbox statistics stage agree on MARK_COLOR_DEFAULT.
package motion_detect_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } bbox_state_t;

    // Colour the highlight stage writes for motion pixels.
    localparam pixel_t MARK_COLOR_DEFAULT = 24'h0000FF;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position tracker for a WIDTH x HEIGHT pixel stream.
// Wraps to (0,0) after the last pixel of a frame.
module pixel_pos_counter #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 576
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    output logic [$clog2(WIDTH)-1:0]  x,
    output logic [$clog2(HEIGHT)-1:0] y,
    output logic                      last
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic end_x;
    logic end_y;

    assign end_x = (x == XW'(WIDTH - 1));
    assign end_y = (y == YW'(HEIGHT - 1));
    assign last  = end_x && end_y;

    // Step the column each advance; roll into the next row at end of line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (end_x) begin
                x <= '0;
                y <= end_y ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/motion_bbox_stats.sv
// Forwards a highlighted pixel stream and gathers per-frame motion stats:
// marked-pixel count, bounding box and a motion flag behind a valid/ack.
module motion_bbox_stats
    import motion_detect_pkg::*;
#(
    parameter int     WIDTH      = 768,
    parameter int     HEIGHT     = 576,
    parameter pixel_t MARK_COLOR = MARK_COLOR_DEFAULT,
    parameter int     MIN_PIXELS = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    input  logic                                 in_empty,
    output logic                                 in_rd_en,
    input  pixel_t                               in_dout,
    input  logic                                 out_full,
    output logic                                 out_wr_en,
    output pixel_t                               out_din,
    output logic                                 stats_valid,
    input  logic                                 stats_ack,
    output logic [$clog2(WIDTH)-1:0]             min_x,
    output logic [$clog2(WIDTH)-1:0]             max_x,
    output logic [$clog2(HEIGHT)-1:0]            min_y,
    output logic [$clog2(HEIGHT)-1:0]            max_y,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pixel_count,
    output logic                                 motion
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH * HEIGHT + 1);

    bbox_state_t   state;
    logic          xfer;
    logic          hit;
    logic          last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic [CW-1:0] acc_count;
    logic [XW-1:0] acc_min_x;
    logic [XW-1:0] acc_max_x;
    logic [YW-1:0] acc_min_y;
    logic [YW-1:0] acc_max_y;

    logic [CW-1:0] nxt_count;
    logic [XW-1:0] nxt_min_x;
    logic [XW-1:0] nxt_max_x;
    logic [YW-1:0] nxt_min_y;
    logic [YW-1:0] nxt_max_y;

    // A pixel moves only when both FIFOs allow it; the data path is a wire.
    assign xfer      = (state == RUN) && !in_empty && !out_full;
    assign in_rd_en  = xfer;
    assign out_wr_en = xfer;
    assign out_din   = in_dout;
    assign hit       = xfer && (in_dout == MARK_COLOR);

    pixel_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clock   (clock),
        .reset   (reset),
        .clear   (start && (state == IDLE)),
        .advance (xfer),
        .x       (x),
        .y       (y),
        .last    (last)
    );

    // Accumulator values including the current pixel, so the final pixel
    // of a frame can be folded straight into the published result.
    always_comb begin
        nxt_count = acc_count;
        nxt_min_x = acc_min_x;
        nxt_max_x = acc_max_x;
        nxt_min_y = acc_min_y;
        nxt_max_y = acc_max_y;
        if (hit) begin
            nxt_count = acc_count + 1'b1;
            if (acc_count == '0) begin
                nxt_min_x = x;
                nxt_max_x = x;
                nxt_min_y = y;
                nxt_max_y = y;
            end else begin
                if (x < acc_min_x) nxt_min_x = x;
                if (x > acc_max_x) nxt_max_x = x;
                if (y < acc_min_y) nxt_min_y = y;
                if (y > acc_max_y) nxt_max_y = y;
            end
        end
    end

    // Frame control, accumulation and the registered result/handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            stats_valid <= 1'b0;
            acc_count   <= '0;
            acc_min_x   <= '0;
            acc_max_x   <= '0;
            acc_min_y   <= '0;
            acc_max_y   <= '0;
            pixel_count <= '0;
            min_x       <= '0;
            max_x       <= '0;
            min_y       <= '0;
            max_y       <= '0;
            motion      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_count <= nxt_count;
                        acc_min_x <= nxt_min_x;
                        acc_max_x <= nxt_max_x;
                        acc_min_y <= nxt_min_y;
                        acc_max_y <= nxt_max_y;
                        if (last) begin
                            state       <= DONE;
                            stats_valid <= 1'b1;
                            pixel_count <= nxt_count;
                            min_x       <= nxt_min_x;
                            max_x       <= nxt_max_x;
                            min_y       <= nxt_min_y;
                            max_y       <= nxt_max_y;
                            motion      <= (nxt_count >= CW'(MIN_PIXELS));
                        end
                    end
                end
                DONE: begin
                    if (stats_ack) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        stats_valid <= 1'b0;
                        acc_count   <= '0;
                        acc_min_x   <= '0;
                        acc_max_x   <= '0;
                        acc_min_y   <= '0;
                        acc_max_y   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motion_bbox_stats.sv
// Randomized bench for motion_bbox_stats on a 4x3 frame.
// FIFO models are queues; stats come from a whole-frame reference scan.
module tb_motion_bbox_stats;

    import motion_detect_pkg::*;

    localparam int     W     = 4;
    localparam int     H     = 3;
    localparam int     N     = W * H;
    localparam int     MINP  = 2;
    localparam pixel_t MARK  = 24'h0000FF;
    localparam pixel_t PLAIN = 24'h101010;

    logic         clock;
    logic         reset;
    logic         start;
    logic         busy;
    logic         in_empty;
    logic         in_rd_en;
    pixel_t       in_dout;
    logic         out_full;
    logic         out_wr_en;
    pixel_t       out_din;
    logic         stats_valid;
    logic         stats_ack;
    logic [1:0]   min_x;
    logic [1:0]   max_x;
    logic [1:0]   min_y;
    logic [1:0]   max_y;
    logic [3:0]   pixel_count;
    logic         motion;

    motion_bbox_stats #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .MARK_COLOR (MARK),
        .MIN_PIXELS (MINP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .in_empty    (in_empty),
        .in_rd_en    (in_rd_en),
        .in_dout     (in_dout),
        .out_full    (out_full),
        .out_wr_en   (out_wr_en),
        .out_din     (out_din),
        .stats_valid (stats_valid),
        .stats_ack   (stats_ack),
        .min_x       (min_x),
        .max_x       (max_x),
        .min_y       (min_y),
        .max_y       (max_y),
        .pixel_count (pixel_count),
        .motion      (motion)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int     checks;
    int     failures;
    int     rw_bad;
    bit     pend;
    pixel_t src_q[$];
    pixel_t out_q[$];
    pixel_t frame[N];
    pixel_t saved[N];

    int     e_count;
    int     e_min_x;
    int     e_max_x;
    int     e_min_y;
    int     e_max_y;
    int     e_motion;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: scan the whole frame in raster order.
    task automatic model();
        e_count = 0;
        e_min_x = 0;
        e_max_x = 0;
        e_min_y = 0;
        e_max_y = 0;
        for (int i = 0; i < N; i++) begin
            if (frame[i] == MARK) begin
                if (e_count == 0) begin
                    e_min_x = i % W;
                    e_max_x = i % W;
                    e_min_y = i / W;
                    e_max_y = i / W;
                end else begin
                    if (i % W < e_min_x) e_min_x = i % W;
                    if (i % W > e_max_x) e_max_x = i % W;
                    if (i / W < e_min_y) e_min_y = i / W;
                    if (i / W > e_max_y) e_max_y = i / W;
                end
                e_count++;
            end
        end
        e_motion = (e_count >= MINP) ? 1 : 0;
    endtask

    task automatic fill_plain();
        for (int i = 0; i < N; i++) frame[i] = PLAIN;
    endtask

    task automatic fill_random(input int nmarks);
        int placed;
        pixel_t p;
        for (int i = 0; i < N; i++) begin
            p = pixel_t'($urandom);
            if (p == MARK) p = PLAIN;
            frame[i] = p;
        end
        placed = 0;
        while (placed < nmarks) begin
            int k;
            k = $urandom_range(N - 1);
            if (frame[k] != MARK) begin
                frame[k] = MARK;
                placed++;
            end
        end
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) src_q.push_back(frame[i]);
    endtask

    // One clock: drive inputs at negedge, observe just after.
    task automatic tick(input bit st, input bit ak, input int stall);
        @(negedge clock);
        if (pend) begin
            void'(src_q.pop_front());
            pend = 1'b0;
        end
        start     = st;
        stats_ack = ak;
        in_empty  = (src_q.size() == 0) || ($urandom_range(99) < stall);
        in_dout   = (src_q.size() != 0) ? src_q[0] : '0;
        out_full  = ($urandom_range(99) < stall);
        #1;
        if (in_rd_en !== out_wr_en) rw_bad++;
        if (in_rd_en === 1'b1) begin
            out_q.push_back(out_din);
            pend = 1'b1;
        end
    endtask

    task automatic run_frame(input string t, input int stall);
        int n;
        bit pre_valid;
        out_q.delete();
        rw_bad    = 0;
        pre_valid = 1'b0;
        tick(1'b1, 1'b0, stall);
        n = 0;
        while (out_q.size() < N && n < 2000) begin
            tick(1'b0, 1'b0, stall);
            pre_valid |= stats_valid;
            n++;
        end
        chk({t, "_timeout"}, (n < 2000), 1);
        tick(1'b0, 1'b0, stall);
        chk({t, "_valid_rise"}, stats_valid, 1);
        chk({t, "_early_valid"}, pre_valid, 0);
        chk({t, "_rd_eq_wr"}, rw_bad, 0);
    endtask

    task automatic check_stats(input string t);
        chk({t, "_count"}, pixel_count, e_count);
        chk({t, "_min_x"}, min_x, e_min_x);
        chk({t, "_max_x"}, max_x, e_max_x);
        chk({t, "_min_y"}, min_y, e_min_y);
        chk({t, "_max_y"}, max_y, e_max_y);
        chk({t, "_motion"}, motion, e_motion);
    endtask

    task automatic check_stream(input string t);
        int bad;
        bad = 0;
        chk({t, "_stream_len"}, out_q.size(), N);
        for (int i = 0; i < N && i < out_q.size(); i++)
            if (out_q[i] !== frame[i]) bad++;
        chk({t, "_stream_data"}, bad, 0);
    endtask

    task automatic ack_frame(input string t, input bit with_start);
        tick(with_start, 1'b1, 0);
        tick(1'b0, 1'b0, 0);
        chk({t, "_valid_fall"}, stats_valid, 0);
        chk({t, "_busy_idle"}, busy, 0);
        if (with_start) begin
            repeat (3) tick(1'b0, 1'b0, 0);
            chk({t, "_start_ignored"}, busy, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rw_bad    = 0;
        pend      = 1'b0;
        reset     = 1'b0;
        start     = 1'b0;
        stats_ack = 1'b0;
        in_empty  = 1'b0;
        in_dout   = MARK;
        out_full  = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_rd_en", in_rd_en, 0);
        chk("rst_wr_en", out_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", stats_valid, 0);
        chk("rst_count", pixel_count, 0);
        chk("rst_motion", motion, 0);
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b1;

        // Frame with no marks.
        fill_plain();
        model();
        load();
        run_frame("empty", 0);
        check_stats("empty");
        check_stream("empty");
        ack_frame("empty", 1'b0);

        // Two marks in opposite corners of the box.
        fill_plain();
        frame[0 * W + 1] = MARK;
        frame[2 * W + 3] = MARK;
        model();
        load();
        run_frame("two", 0);
        check_stats("two");
        check_stream("two");
        ack_frame("two", 1'b0);

        // Single mark, below threshold.
        fill_plain();
        frame[1 * W + 2] = MARK;
        model();
        load();
        run_frame("one", 0);
        check_stats("one");
        check_stream("one");
        ack_frame("one", 1'b0);

        // Five marks: once free-running, once with heavy stalls.
        fill_random(5);
        model();
        load();
        run_frame("r5", 0);
        check_stats("r5");
        check_stream("r5");
        ack_frame("r5", 1'b0);
        load();
        run_frame("r5st", 30);
        check_stats("r5st");
        check_stream("r5st");
        ack_frame("r5st", 1'b1);

        // Several random stalled frames.
        for (int f = 0; f < 6; f++) begin
            fill_random($urandom_range(N));
            model();
            load();
            run_frame("rnd", 30);
            check_stats("rnd");
            check_stream("rnd");
            ack_frame("rnd", 1'b0);
        end

        // Hold the result while the next frame waits upstream.
        fill_random(4);
        model();
        load();
        run_frame("bpA", 0);
        check_stats("bpA");
        for (int i = 0; i < N; i++) saved[i] = frame[i];
        fill_random(2);
        load();
        out_q.delete();
        repeat (20) tick(1'b0, 1'b0, 0);
        chk("bp_no_pop", out_q.size(), 0);
        chk("bp_src_kept", src_q.size(), N);
        chk("bp_valid_held", stats_valid, 1);
        check_stats("bp_hold");
        ack_frame("bpA", 1'b0);
        model();
        run_frame("bpB", 0);
        check_stats("bpB");
        check_stream("bpB");
        ack_frame("bpB", 1'b0);

        // Reset in the middle of a frame, then a fresh frame.
        fill_random(6);
        load();
        out_q.delete();
        tick(1'b1, 1'b0, 0);
        for (int n = 0; n < 200 && out_q.size() < 7; n++)
            tick(1'b0, 1'b0, 0);
        chk("mid_reached7", out_q.size(), 7);
        @(negedge clock);
        reset    = 1'b0;
        pend     = 1'b0;
        src_q.delete();
        in_empty = 1'b0;
        in_dout  = MARK;
        #1;
        chk("mid_rd_in_reset", in_rd_en, 0);
        chk("mid_valid_in_reset", stats_valid, 0);
        repeat (2) @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b1;
        fill_plain();
        frame[2]  = MARK;
        frame[5]  = MARK;
        frame[10] = MARK;
        model();
        load();
        run_frame("after_rst", 0);
        check_stats("after_rst");
        check_stream("after_rst");
        chk("after_rst_count3", pixel_count, 3);
        ack_frame("after_rst", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_bbox_stats.md
Name: motion_bbox_stats

Overview:
- Downstream of motion_detect_top.
- Pops highlighted 24-bit pixels from the top's output FIFO and forwards them unchanged to a downstream FIFO (image writer / display).
- Per frame, counts pixels equal to the highlight colour and records the bounding box of those pixels. Publishes the result through a valid/ack handshake.
- Gives control software a per-frame "motion present" decision without re-reading the image.

Parameters:
WIDTH, 768, pixels per row
HEIGHT, 576, rows per frame
MARK_COLOR, 24'h0000FF, exact 24-bit value the upstream stage writes for motion pixels (byte order as on in_dout)
MIN_PIXELS, 64, minimum marked-pixel count for motion=1

Ports:
clock  input  1  clock
reset  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; arms processing of one frame
busy  output  1  high in RUN or DONE
in_empty  input  1  upstream show-ahead FIFO empty
in_rd_en  output  1  pop upstream FIFO
in_dout  input  24  upstream pixel, valid while in_empty=0
out_full  input  1  downstream FIFO full
out_wr_en  output  1  push downstream FIFO
out_din  output  24  forwarded pixel
stats_valid  output  1  frame result available
stats_ack  input  1  consumer accepts result
min_x, max_x  output  $clog2(WIDTH)  bounding-box columns
min_y, max_y  output  $clog2(HEIGHT)  bounding-box rows (stream order, row 0 first)
pixel_count  output  $clog2(WIDTH*HEIGHT+1)  marked pixels in frame
motion  output  1  pixel_count >= MIN_PIXELS

Behaviour:
- Reset (async, active-low): state=IDLE; x=y=0; accumulators cleared; all outputs 0. in_rd_en/out_wr_en are low while reset is asserted. Reset mid-frame abandons the frame; no partial result is published.
- FSM IDLE -> RUN on start. RUN -> DONE when the pixel at x=WIDTH-1, y=HEIGHT-1 is transferred. DONE -> IDLE on stats_ack. start outside IDLE is ignored.
- Transfer: in_rd_en = out_wr_en = (state==RUN) && !in_empty && !out_full. out_din = in_dout, combinational, zero added latency. No pixel is dropped or duplicated under any empty/full pattern.
- Position: x increments on each transfer. At WIDTH-1, x wraps to 0 and y increments. At the last pixel, both x and y reset to 0.
- Accumulate on transfer when in_dout==MARK_COLOR:
  - count+1
  - min_x=min(min_x,x), max_x=max(max_x,x), min_y=min(min_y,y), max_y=max(max_y,y)
  - The first marked pixel initialises all four bounds.
- Publish: result registers load in the cycle the last pixel transfers, folding in that pixel. stats_valid rises the next cycle. Results hold stable while stats_valid=1.
- Empty frame (count 0): min_x=max_x=min_y=max_y=0, pixel_count=0, motion=0.
- Clear: accumulators clear when leaving DONE. stats_valid falls the cycle after stats_ack. stats_ack while stats_valid=0 is ignored.
- Back-pressure: in DONE no pops occur, so the next frame waits in the FIFOs until ack plus start.
- Simultaneous stats_ack and start in DONE: ack taken, start ignored; a new start is required in IDLE.
- Widths: count never saturates; WIDTH*HEIGHT fits by construction.

Decomposition:
- Package motion_detect_pkg:
  - PIXEL_W=24
  - typedef pixel_t (logic [23:0])
  - typedef enum bbox_state_t {IDLE, RUN, DONE}
  - shared default MARK_COLOR constant, also used by the highlight stage
- One sub-module, pixel_pos_counter (WIDTH, HEIGHT). Ports: clock, reset, clear, advance. Outputs x, y, last. Reused by other stream stages.

Test Plan (bench WIDTH=4, HEIGHT=3, MIN_PIXELS=2, FIFOs never empty/full unless stated):
- All 12 pixels 24'h101010 -> 12 forwarded identically. stats_valid 1 cycle after 12th pop. count=0, bbox=0,0,0,0, motion=0.
- Marks at (1,0),(3,2) -> count=2, min_x=1, max_x=3, min_y=0, max_y=2, motion=1. Output stream bit-identical to input.
- Single mark at (2,1) -> count=1, bbox=2,2,1,1, motion=0.
- Random in_empty/out_full toggling (~30% each) over a frame with 5 marks -> exactly 12 pushes in order. Identical stats to the no-stall run.
- After DONE, hold stats_ack low 20 cycles with frame-2 data queued -> no pops, outputs stable. Ack, then start -> frame 2 stats independent of frame 1.
- Assert reset after 7 pixels, release, start, send a full frame with 3 marks -> stats reflect only the new frame: count=3.
